onehot_to_binary_rx: RTL and testbench

- Receiving end of the binary-to-one-hot link: accepts one-hot words and recovers the binary index.
- Checks every word for one-hot legality and flags zero or multi-hot codes.
- Keeps saturating word and error counters.
- Registered, valid/ready on both sides; sits after a one-hot transmitter, feeds a binary consumer.

---
 rtl/onehot_rx_pkg.sv | 29 ++
 rtl/onehot_decode.sv | 24 ++
 rtl/onehot_to_binary_rx.sv | 90 +++++++++
 tb/tb_onehot_to_binary_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/onehot_rx_pkg.sv
// Shared types and defaults for the one-hot receive path.
package onehot_rx_pkg;

    localparam int OH_W_DEF  = 16;
    localparam int BIN_W_DEF = $clog2(OH_W_DEF);
    localparam int CNT_W_DEF = 8;

    // Legality class of a received word.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ZERO  = 2'd1,
        ERR_MULTI = 2'd2
    } oh_err_e;

    // One decoded word at the default width.
    typedef struct packed {
        logic [BIN_W_DEF-1:0] binary;
        oh_err_e              err;
    } rx_word_t;

    // Collapse the decoder flags into a legality class; zero wins, though
    // both flags can never be set together.
    function automatic oh_err_e classify(input logic zero, input logic multi);
        if (zero)       return ERR_ZERO;
        else if (multi) return ERR_MULTI;
        else            return ERR_NONE;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot decoder: lowest set bit index plus legality flags.
module onehot_decode #(
    parameter int OH_W  = 16,
    parameter int BIN_W = $clog2(OH_W)
) (
    input  logic [OH_W-1:0]  onehot,
    output logic [BIN_W-1:0] index,
    output logic             is_zero,
    output logic             is_multi
);

    // Scan from the top down so the last hit is the lowest set bit.
    always_comb begin
        index = '0;
        for (int k = OH_W - 1; k >= 0; k--) begin
            if (onehot[k]) index = BIN_W'(k);
        end
    end

    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign is_zero  = ~|onehot;
    assign is_multi = |(onehot & (onehot - OH_W'(1)));

endmodule

// File: rtl/onehot_to_binary_rx.sv
// One-hot receiver: registered decode with valid/ready on both sides and
// saturating word / error counters.
module onehot_to_binary_rx
    import onehot_rx_pkg::*;
#(
    parameter int OH_W  = OH_W_DEF,
    parameter int BIN_W = $clog2(OH_W),
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             oh_valid_i,
    output logic             oh_ready_o,
    input  logic [OH_W-1:0]  onehot_i,
    output logic             bin_valid_o,
    input  logic             bin_ready_i,
    output logic [BIN_W-1:0] binary_o,
    output logic             err_zero_o,
    output logic             err_multi_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    logic [BIN_W-1:0] dec_idx;
    logic             dec_zero;
    logic             dec_multi;
    oh_err_e          dec_err;
    logic             accept;
    logic             illegal;

    logic             vld_q;
    logic [BIN_W-1:0] bin_q;
    oh_err_e          err_q;
    logic [CNT_W-1:0] word_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    onehot_decode #(
        .OH_W  (OH_W),
        .BIN_W (BIN_W)
    ) u_decode (
        .onehot   (onehot_i),
        .index    (dec_idx),
        .is_zero  (dec_zero),
        .is_multi (dec_multi)
    );

    assign dec_err    = classify(dec_zero, dec_multi);
    assign illegal    = dec_zero | dec_multi;
    // Slot frees up when empty or being drained this cycle.
    assign oh_ready_o = !vld_q || bin_ready_i;
    assign accept     = oh_valid_i && oh_ready_o;

    // Output register: load on accept, release on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            bin_q <= '0;
            err_q <= ERR_NONE;
        end else if (accept) begin
            vld_q <= 1'b1;
            bin_q <= dec_idx;
            err_q <= dec_err;
        end else if (bin_ready_i) begin
            vld_q <= 1'b0;
        end
    end

    // Saturating counters; a clear still credits a same-cycle accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else if (clr_cnt_i) begin
            word_cnt_q <= CNT_W'(accept);
            err_cnt_q  <= CNT_W'(accept && illegal);
        end else if (accept) begin
            if (word_cnt_q != '1)            word_cnt_q <= word_cnt_q + 1'b1;
            if (illegal && err_cnt_q != '1)  err_cnt_q  <= err_cnt_q + 1'b1;
        end
    end

    assign bin_valid_o = vld_q;
    assign binary_o    = bin_q;
    assign err_zero_o  = (err_q == ERR_ZERO);
    assign err_multi_o = (err_q == ERR_MULTI);
    assign word_cnt_o  = word_cnt_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_onehot_to_binary_rx.sv
// Bench for onehot_to_binary_rx: directed steps plus random traffic checked
// against a transaction-level reference model.
module tb_onehot_to_binary_rx;

    localparam int OH_W  = 16;
    localparam int BIN_W = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             oh_valid_i;
    logic             oh_ready_o;
    logic [OH_W-1:0]  onehot_i;
    logic             bin_valid_o;
    logic             bin_ready_i;
    logic [BIN_W-1:0] binary_o;
    logic             err_zero_o;
    logic             err_multi_o;
    logic             clr_cnt_i;
    logic [CNT_W-1:0] word_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_valid;
    int m_bin;
    bit m_zero, m_multi;
    int m_wcnt, m_ecnt;

    always #5 clk = ~clk;

    onehot_to_binary_rx #(.OH_W(OH_W), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .oh_valid_i  (oh_valid_i),
        .oh_ready_o  (oh_ready_o),
        .onehot_i    (onehot_i),
        .bin_valid_o (bin_valid_o),
        .bin_ready_i (bin_ready_i),
        .binary_o    (binary_o),
        .err_zero_o  (err_zero_o),
        .err_multi_o (err_multi_o),
        .clr_cnt_i   (clr_cnt_i),
        .word_cnt_o  (word_cnt_o),
        .err_cnt_o   (err_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lowest set bit, zero and multi-hot status straight from the word.
    function automatic void ref_decode(input logic [OH_W-1:0] w, output int idx,
                                       output bit z, output bit m);
        idx = 0;
        for (int k = OH_W - 1; k >= 0; k--) if (w[k]) idx = k;
        z = (w == '0);
        m = ($countones(w) > 1);
    endfunction

    // One clock: drive inputs, check ready, advance model, check outputs.
    task automatic step(input bit v, input logic [OH_W-1:0] w, input bit rdy,
                        input bit clr, input bit rst);
        bit acc, z, m;
        int idx;
        reset = rst; oh_valid_i = v; onehot_i = w; bin_ready_i = rdy; clr_cnt_i = clr;
        #1;
        if (!rst) check("oh_ready", oh_ready_o, !m_valid || rdy);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_bin = 0; m_zero = 0; m_multi = 0; m_wcnt = 0; m_ecnt = 0;
        end else begin
            acc = v && (!m_valid || rdy);
            ref_decode(w, idx, z, m);
            if (acc) begin
                m_valid = 1; m_bin = idx; m_zero = z; m_multi = m;
            end else if (rdy) begin
                m_valid = 0;
            end
            if (clr) begin
                m_wcnt = acc ? 1 : 0;
                m_ecnt = (acc && (z || m)) ? 1 : 0;
            end else if (acc) begin
                m_wcnt = (m_wcnt + 1 > CMAX) ? CMAX : m_wcnt + 1;
                if (z || m) m_ecnt = (m_ecnt + 1 > CMAX) ? CMAX : m_ecnt + 1;
            end
        end
        #1;
        check("bin_valid", bin_valid_o, m_valid);
        if (m_valid) begin
            check("binary", binary_o, m_bin);
            check("err_zero", err_zero_o, m_zero);
            check("err_multi", err_multi_o, m_multi);
        end
        check("word_cnt", word_cnt_o, m_wcnt);
        check("err_cnt", err_cnt_o, m_ecnt);
    endtask

    function automatic logic [OH_W-1:0] rand_word();
        int sel = $urandom_range(0, 9);
        if (sel == 0)      return '0;
        else if (sel <= 2) return OH_W'($urandom);
        else               return OH_W'(1) << $urandom_range(0, OH_W - 1);
    endfunction

    initial begin
        logic [OH_W-1:0] w;
        m_valid = 0; m_bin = 0; m_zero = 0; m_multi = 0; m_wcnt = 0; m_ecnt = 0;

        // Reset state
        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 0, 1);
        check("rst_binary", binary_o, 0);
        check("rst_zero", err_zero_o, 0);
        check("rst_multi", err_multi_o, 0);

        // Single word, one-cycle latency
        step(1, 16'h0100, 1, 0, 0);
        check("first_valid", bin_valid_o, 1);
        check("first_bin", binary_o, 8);
        check("first_wcnt", word_cnt_o, 1);
        check("first_ecnt", err_cnt_o, 0);
        step(0, '0, 1, 0, 0);

        // Back-to-back sweep
        for (int i = 0; i < OH_W; i++) begin
            w = OH_W'(1) << i;
            step(1, w, 1, 0, 0);
            check("sweep_bin", binary_o, i);
        end
        check("sweep_wcnt", word_cnt_o, 17);
        step(0, '0, 1, 0, 0);

        // Illegal words
        step(1, 16'h0000, 1, 0, 0);
        check("zero_flag", err_zero_o, 1);
        check("zero_bin", binary_o, 0);
        step(1, 16'h0A00, 1, 0, 0);
        check("multi_flag", err_multi_o, 1);
        check("multi_bin", binary_o, 9);
        check("illegal_ecnt", err_cnt_o, 2);
        step(0, '0, 1, 0, 0);

        // Backpressure: word held stable, input stalled
        step(1, 16'h0010, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 16'h0020, 0, 0, 0);
            check("bp_bin", binary_o, 4);
            check("bp_ready", oh_ready_o, 0);
            check("bp_wcnt", word_cnt_o, 20);
        end
        step(1, 16'h0020, 1, 0, 0);
        check("bp_release_bin", binary_o, 5);
        check("bp_release_valid", bin_valid_o, 1);
        step(0, '0, 1, 0, 0);

        // Saturation with random legal/illegal words
        for (int i = 0; i < 300; i++) step(1, rand_word(), 1, 0, 0);
        check("sat_wcnt", word_cnt_o, CMAX);

        // Clear with a same-cycle illegal accept
        step(1, 16'h0003, 1, 1, 0);
        check("clr_wcnt", word_cnt_o, 1);
        check("clr_ecnt", err_cnt_o, 1);
        check("clr_bin", binary_o, 0);

        // Random traffic with random backpressure and occasional clears
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 49) == 0, 0);

        // Reset with a held word
        step(1, 16'h0040, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(1, 16'h0080, 0, 0, 1);
        check("midrst_valid", bin_valid_o, 0);
        check("midrst_wcnt", word_cnt_o, 0);
        check("midrst_ecnt", err_cnt_o, 0);
        step(1, 16'h0400, 1, 0, 0);
        check("postrst_bin", binary_o, 10);
        check("postrst_wcnt", word_cnt_o, 1);
        step(0, '0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
